// File: rtl/dtc_tree_walker.sv
// dtc_tree_walker: table-driven decision-tree engine.
// A node table is loaded through the cfg port while the engine is idle.
// Each accepted feature vector is classified by walking the table from
// entry 0, one node per cycle. The result is held on a valid/ready output.
// Optional build macro: DTC_WALK_STATS_EN adds saturating result counters.
module dtc_tree_walker #(
    parameter int FEAT_W    = 8,
    parameter int CLS_W     = 2,
    parameter int NODE_AW   = 6,
    parameter int MAX_DEPTH = 8,
    localparam int FIDX_W   = $clog2(FEAT_W),
    localparam int NODE_W   = 1 + FIDX_W + 2*NODE_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    output logic               cfg_ready,
    input  logic [NODE_AW-1:0] cfg_addr,
    input  logic [NODE_W-1:0]  cfg_wdata,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FEAT_W-1:0]  in_feat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLS_W-1:0]   out_class,
    output logic               out_err,
    output logic               busy
`ifdef DTC_WALK_STATS_EN
    ,
    output logic [15:0]        stat_cls_cnt,
    output logic [15:0]        stat_err_cnt
`endif
);

    localparam int unsigned DEPTH  = 2**NODE_AW;
    localparam int          STEP_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [NODE_W-1:0]   r_table [DEPTH];
    logic [NODE_AW-1:0]  r_ptr;
    logic [STEP_W-1:0]   r_step;
    logic [FEAT_W-1:0]   r_feat;
    logic [CLS_W-1:0]    r_out_class;
    logic                r_out_err;
    logic                r_out_valid;

    state_t              w_state_nx;
    logic [NODE_AW-1:0]  w_ptr_nx;
    logic [STEP_W-1:0]   w_step_nx;
    logic [FEAT_W-1:0]   w_feat_nx;
    logic [CLS_W-1:0]    w_cls_nx;
    logic                w_err_nx;
    logic                w_vld_nx;

    // Current node fields, decoded from the entry addressed by r_ptr
    logic [NODE_W-1:0]   w_node;
    logic                w_leaf;
    logic [FIDX_W-1:0]   w_fidx;
    logic [NODE_AW-1:0]  w_left;
    logic [NODE_AW-1:0]  w_right;
    logic                w_fbit;
    logic                w_idle;
    logic                w_hshake;

    assign w_node   = r_table[r_ptr];
    assign w_leaf   = w_node[NODE_W-1];
    assign w_fidx   = w_node[NODE_W-2 -: FIDX_W];
    assign w_left   = w_node[2*NODE_AW-1 -: NODE_AW];
    assign w_right  = w_node[NODE_AW-1:0];
    assign w_idle   = (r_state == IDLE);
    assign w_hshake = r_out_valid && out_ready;

    // Out-of-range feature indices read as 0
    always_comb begin
        w_fbit = 1'b0;
        if (int'(w_fidx) < FEAT_W)
            w_fbit = r_feat[w_fidx];
    end

    // Node table: cleared on reset, writable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_table[i] <= '0;
        end else if (cfg_we && w_idle) begin
            r_table[cfg_addr] <= cfg_wdata;
        end
    end

    // State and walk/result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_step      <= '0;
            r_feat      <= '0;
            r_out_class <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_step      <= w_step_nx;
            r_feat      <= w_feat_nx;
            r_out_class <= w_cls_nx;
            r_out_err   <= w_err_nx;
            r_out_valid <= w_vld_nx;
        end
    end

    // Next-state: accept in IDLE, one node per cycle in WALK, hold in DONE
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_step_nx  = r_step;
        w_feat_nx  = r_feat;
        w_cls_nx   = r_out_class;
        w_err_nx   = r_out_err;
        w_vld_nx   = r_out_valid;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_feat_nx  = in_feat;
                    w_ptr_nx   = '0;
                    w_step_nx  = '0;
                    w_state_nx = WALK;
                end
            end
            WALK: begin
                if (w_leaf) begin
                    w_cls_nx   = w_node[CLS_W-1:0];
                    w_err_nx   = 1'b0;
                    w_vld_nx   = 1'b1;
                    w_state_nx = DONE;
                end else if (r_step == STEP_W'(MAX_DEPTH-1)) begin
                    w_cls_nx   = '0;
                    w_err_nx   = 1'b1;
                    w_vld_nx   = 1'b1;
                    w_state_nx = DONE;
                end else begin
                    w_ptr_nx  = w_fbit ? w_right : w_left;
                    w_step_nx = r_step + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_vld_nx   = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign in_ready  = w_idle;
    assign cfg_ready = w_idle;
    assign busy      = !w_idle;
    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_err   = r_out_err;

`ifdef DTC_WALK_STATS_EN
    logic [15:0] r_stat_cls;
    logic [15:0] r_stat_err;

    // Saturating counts of handshaked results, split by error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cls <= '0;
            r_stat_err <= '0;
        end else if (w_hshake) begin
            if (r_out_err) begin
                if (r_stat_err != '1)
                    r_stat_err <= r_stat_err + 16'd1;
            end else begin
                if (r_stat_cls != '1)
                    r_stat_cls <= r_stat_cls + 16'd1;
            end
        end
    end

    assign stat_cls_cnt = r_stat_cls;
    assign stat_err_cnt = r_stat_err;
`else
    logic w_unused;
    assign w_unused = w_hshake;
`endif

endmodule

// File: tb/tb_dtc_tree_walker.sv
// Directed self-checking bench for dtc_tree_walker.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_dtc_tree_walker;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic        cfg_ready;
    logic [5:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_feat;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_class;
    logic        out_err;
    logic        busy;
`ifdef DTC_WALK_STATS_EN
    logic [15:0] stat_cls_cnt;
    logic [15:0] stat_err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    dtc_tree_walker #(
        .FEAT_W    (8),
        .CLS_W     (2),
        .NODE_AW   (6),
        .MAX_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .busy      (busy)
`ifdef DTC_WALK_STATS_EN
        ,
        .stat_cls_cnt (stat_cls_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Counts edges until out_valid, bounded at 20
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic do_walk(input string tag, input logic [7:0] f, input int exp_lat,
                           input logic [1:0] exp_cls, input logic exp_err);
        int l;
        in_valid = 1'b1;
        in_feat  = f;
        tick();
        in_valid = 1'b0;
        wait_valid(l);
        check({tag, "_lat"}, l, exp_lat);
        check({tag, "_cls"}, out_class, exp_cls);
        check({tag, "_err"}, out_err, exp_err);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_clr"}, out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_out_err",   out_err,   1'b0);
        check("rst_out_class", out_class, 2'b00);

        // Empty table: root self-loops, error after MAX_DEPTH edges
        in_valid = 1'b1;
        in_feat  = 8'h00;
        tick();
        in_valid = 1'b0;
        check("walk_busy",     busy,      1'b1);
        check("walk_in_ready", in_ready,  1'b0);
        wait_valid(lat);
        check("empty_lat", lat,       8);
        check("empty_err", out_err,   1'b1);
        check("empty_cls", out_class, 2'b00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("empty_vld_clr", out_valid, 1'b0);
        check("empty_idle",    in_ready,  1'b1);

        // Depth-1 tree split on feature bit 6
        cfg_write(6'd0, 16'h6042);
        cfg_write(6'd1, 16'h8001);
        cfg_write(6'd2, 16'h8002);
        do_walk("t1_f40", 8'h40, 2, 2'b10, 1'b0);
        do_walk("t1_fbf", 8'hBF, 2, 2'b01, 1'b0);

        // Write and accept in the same cycle: walk sees the new root leaf
        cfg_we    = 1'b1;
        cfg_addr  = 6'd0;
        cfg_wdata = 16'h8003;
        in_valid  = 1'b1;
        in_feat   = 8'h40;
        tick();
        cfg_we    = 1'b0;
        in_valid  = 1'b0;
        wait_valid(lat);
        check("same_lat", lat,       1);
        check("same_cls", out_class, 2'b11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        do_walk("rootleaf_ff", 8'hFF, 1, 2'b11, 1'b0);

        // Backpressure in DONE with in_valid held high
        in_valid = 1'b1;
        in_feat  = 8'h00;
        tick();
        wait_valid(lat);
        check("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_vld",      out_valid, 1'b1);
            check("bp_cls",      out_class, 2'b11);
            check("bp_err",      out_err,   1'b0);
            check("bp_in_ready", in_ready,  1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_vld",  out_valid, 1'b0);
        check("bp_hs_idle", in_ready,  1'b1);
        check("bp_hs_busy", busy,      1'b0);
        tick();
        in_valid = 1'b0;
        check("bp_next_acc", busy, 1'b1);
        wait_valid(lat);
        check("bp_next_lat", lat,       1);
        check("bp_next_cls", out_class, 2'b11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // cfg write during WALK is dropped
        cfg_write(6'd0, 16'h6042);
        in_valid = 1'b1;
        in_feat  = 8'h00;
        tick();
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_addr  = 6'd1;
        cfg_wdata = 16'h8003;
        check("drop_cfg_ready", cfg_ready, 1'b0);
        tick();
        cfg_we = 1'b0;
        wait_valid(lat);
        check("drop_lat", lat,       1);
        check("drop_cls", out_class, 2'b01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        do_walk("drop_again", 8'h00, 2, 2'b01, 1'b0);

        // Reset mid-walk clears the table and the pending walk
        in_valid = 1'b1;
        in_feat  = 8'h40;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready,  1'b1);
        check("midrst_vld",      out_valid, 1'b0);
        check("midrst_busy",     busy,      1'b0);
        do_walk("midrst_cleared", 8'h40, 8, 2'b00, 1'b1);

`ifdef DTC_WALK_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stat_rst_cls", stat_cls_cnt, 16'd0);
        check("stat_rst_err", stat_err_cnt, 16'd0);
        cfg_write(6'd0, 16'h8001);
        do_walk("stat_g1", 8'h00, 1, 2'b01, 1'b0);
        do_walk("stat_g2", 8'h11, 1, 2'b01, 1'b0);
        do_walk("stat_g3", 8'h22, 1, 2'b01, 1'b0);
        cfg_write(6'd0, 16'h0000);
        do_walk("stat_e1", 8'h00, 8, 2'b00, 1'b1);
        check("stat_cls3", stat_cls_cnt, 16'd3);
        check("stat_err1", stat_err_cnt, 16'd1);
        force dut.r_stat_cls = 16'hFFFF;
        tick();
        release dut.r_stat_cls;
        cfg_write(6'd0, 16'h8002);
        do_walk("stat_sat", 8'h00, 1, 2'b10, 1'b0);
        check("stat_cls_sat", stat_cls_cnt, 16'hFFFF);
        check("stat_err_hold", stat_err_cnt, 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
